// File: rtl/sobel_pkg.sv
// Shared definitions for the streaming Sobel edge detector.
//   PIX_W_DEF : default pixel width
//   mag_w()   : magnitude width for a given pixel width (8*(2^P-1) fits in P+3 bits)
//   state_t   : control FSM encoding
//   window_t  : 3x3 window at default pixel width, p0..p8 row-major, p4 centre
package sobel_pkg;
   localparam int PIX_W_DEF = 8;

   function automatic int mag_w(input int pix_w);
      return pix_w + 3;
   endfunction

   typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

   typedef logic [8:0][PIX_W_DEF-1:0] window_t;
endpackage

// File: rtl/sobel_kernel.sv
// Combinational 3x3 Sobel magnitude.
//   i_win : 3x3 window, element i = p_i (row-major, p4 centre)
//   o_mag : |Gx| + |Gy|
module sobel_kernel
   import sobel_pkg::*;
#(
   parameter  int PIX_W = PIX_W_DEF,
   localparam int MAG_W = mag_w(PIX_W)
) (
   input  logic [8:0][PIX_W-1:0] i_win,
   output logic [MAG_W-1:0]      o_mag
);
   localparam int SW = MAG_W + 1;
   localparam int KX [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
   localparam int KY [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

   logic signed [SW-1:0] w_gx, w_gy, w_ax, w_ay, w_p;

   always_comb begin
      w_gx = '0;
      w_gy = '0;
      w_p  = '0;
      for (int i = 0; i < 9; i++) begin
         w_p  = $signed(SW'(i_win[i]));
         w_gx = w_gx + SW'(KX[i]) * w_p;
         w_gy = w_gy + SW'(KY[i]) * w_p;
      end
      w_ax = w_gx[SW-1] ? -w_gx : w_gx;
      w_ay = w_gy[SW-1] ? -w_gy : w_gy;
   end

   // Sum is bounded by 8*(2^PIX_W-1), so the narrowing never loses bits.
   assign o_mag = MAG_W'(w_ax + w_ay);
endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector, one pixel per cycle, raster order.
//   clk, rst_n            : clock, async active-low reset
//   threshold             : edge threshold, latched on pixel (0,0) of each frame
//   in_valid/in_ready     : input pixel handshake, in_pix pixel value
//   out_valid/out_ready   : result handshake
//   out_mag, out_edge     : |Gx|+|Gy| of centre pixel, and mag > threshold
//   out_sof, out_eof      : result is first / last pixel of the frame
// Results lag input by WIDTH+1 pixels; after the last pixel, WIDTH+1 zero
// pixels are pushed internally (FLUSH) to drain the tail of the frame.
module sobel_stream
   import sobel_pkg::*;
#(
   parameter  int WIDTH  = 128,
   parameter  int HEIGHT = 128,
   parameter  int PIX_W  = PIX_W_DEF,
   localparam int MAG_W  = mag_w(PIX_W)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [MAG_W-1:0] threshold,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] in_pix,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [MAG_W-1:0] out_mag,
   output logic             out_edge,
   output logic             out_sof,
   output logic             out_eof
);
   localparam int D  = WIDTH + 1;
   localparam int N  = WIDTH * HEIGHT;
   localparam int XW = $clog2(WIDTH);
   localparam int YW = $clog2(HEIGHT);
   localparam int CW = $clog2(N + 1);

   state_t             r_state, w_state_nxt;
   logic [XW-1:0]      r_x, r_ox;
   logic [YW-1:0]      r_oy;
   logic [CW-1:0]      r_cnt;
   logic [MAG_W-1:0]   r_thr;
   logic [PIX_W-1:0]   r_lb0 [WIDTH];
   logic [PIX_W-1:0]   r_lb1 [WIDTH];
   // Only the two most recent window columns are stored; the third is the
   // incoming column, so the kernel always sees the post-shift window.
   logic [2:0][PIX_W-1:0] r_col1, r_col2;

   logic                  w_can, w_acc, w_flush_step, w_adv, w_emit, w_done;
   logic                  w_ox_last, w_oy_last, w_border;
   logic [PIX_W-1:0]      w_p, w_top, w_mid;
   logic [8:0][PIX_W-1:0] w_win_nxt;
   logic [MAG_W-1:0]      w_mag;

   assign w_can        = !out_valid || out_ready;
   assign in_ready     = (r_state != FLUSH) && w_can;
   assign w_acc        = in_valid && in_ready;
   assign w_flush_step = (r_state == FLUSH) && w_can;
   assign w_adv        = w_acc || w_flush_step;
   assign w_emit       = ((r_state == RUN) && w_acc) || w_flush_step;

   assign w_ox_last = (r_ox == XW'(WIDTH - 1));
   assign w_oy_last = (r_oy == YW'(HEIGHT - 1));
   assign w_border  = (r_ox == '0) || w_ox_last || (r_oy == '0) || w_oy_last;
   // Last flush emit is the last pixel of the frame.
   assign w_done    = w_flush_step && w_ox_last && w_oy_last;

   assign w_p   = (r_state == FLUSH) ? '0 : in_pix;
   assign w_top = r_lb1[r_x];
   assign w_mid = r_lb0[r_x];

   assign w_win_nxt = {w_p,   r_col2[2], r_col1[2],
                       w_mid, r_col2[1], r_col1[1],
                       w_top, r_col2[0], r_col1[0]};

   sobel_kernel #(.PIX_W(PIX_W)) u_kernel (
      .i_win (w_win_nxt),
      .o_mag (w_mag)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (w_acc) w_state_nxt = FILL;
         FILL:    if (w_acc && r_cnt == CW'(D - 1)) w_state_nxt = RUN;
         RUN:     if (w_acc && r_cnt == CW'(N - 1)) w_state_nxt = FLUSH;
         FLUSH:   if (w_done) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x    <= '0;
         r_cnt  <= '0;
         r_thr  <= '0;
         r_ox   <= '0;
         r_oy   <= '0;
         r_col1 <= '0;
         r_col2 <= '0;
      end else begin
         if (w_acc && r_state == IDLE) r_thr <= threshold;
         if (w_done)     r_cnt <= '0;
         else if (w_acc) r_cnt <= r_cnt + 1'b1;
         // Flush runs past the line end, so realign the column for the next frame.
         if (w_done)     r_x <= '0;
         else if (w_adv) r_x <= (r_x == XW'(WIDTH - 1)) ? '0 : r_x + 1'b1;
         if (w_adv) begin
            r_col1 <= r_col2;
            r_col2 <= {w_p, w_mid, w_top};
         end
         if (w_emit) begin
            r_ox <= w_ox_last ? '0 : r_ox + 1'b1;
            if (w_ox_last) r_oy <= w_oy_last ? '0 : r_oy + 1'b1;
         end
      end
   end

   // Line buffers: no reset so they map onto RAM.
   always_ff @(posedge clk) begin
      if (w_adv) begin
         r_lb1[r_x] <= w_mid;
         r_lb0[r_x] <= w_p;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_mag   <= '0;
         out_edge  <= 1'b0;
         out_sof   <= 1'b0;
         out_eof   <= 1'b0;
      end else if (w_emit) begin
         out_valid <= 1'b1;
         out_mag   <= w_border ? '0 : w_mag;
         out_edge  <= !w_border && (w_mag > r_thr);
         out_sof   <= (r_ox == '0) && (r_oy == '0);
         out_eof   <= w_ox_last && w_oy_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_sobel_stream.sv
module tb_sobel_stream;
   localparam int W  = 8;
   localparam int H  = 6;
   localparam int NP = W * H;
   localparam int MW = 11;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [MW-1:0] threshold = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [7:0]    in_pix = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [MW-1:0] out_mag;
   logic          out_edge, out_sof, out_eof;

   always #5 clk = ~clk;

   sobel_stream #(.WIDTH(W), .HEIGHT(H), .PIX_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .threshold(threshold),
      .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
      .out_valid(out_valid), .out_ready(out_ready), .out_mag(out_mag),
      .out_edge(out_edge), .out_sof(out_sof), .out_eof(out_eof)
   );

   int n_chk = 0, n_bad = 0, n_res = 0, n_stall = 0;
   int sink_mode = 0, sink_cyc = 0;
   int img [NP];
   logic [MW+2:0] sb [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int px(input int x, input int y);
      return img[y*W + x];
   endfunction

   // Reference: full-frame Sobel, borders zero; packed {mag, edge, sof, eof}.
   function automatic logic [MW+2:0] model(input int k, input int thr);
      int x, y, gx, gy, mag;
      logic e;
      x = k % W; y = k / W; mag = 0; e = 1'b0;
      if (x > 0 && x < W-1 && y > 0 && y < H-1) begin
         gx = (px(x+1,y-1) + 2*px(x+1,y) + px(x+1,y+1)) - (px(x-1,y-1) + 2*px(x-1,y) + px(x-1,y+1));
         gy = (px(x-1,y+1) + 2*px(x,y+1) + px(x+1,y+1)) - (px(x-1,y-1) + 2*px(x,y-1) + px(x+1,y-1));
         mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
         e = (mag > thr);
      end
      return {MW'(mag), e, (k == 0), (k == NP-1)};
   endfunction

   // Sink: out_ready pattern, updated 2 time units after each rising edge.
   initial forever begin
      @(posedge clk); #2;
      case (sink_mode)
         0:       out_ready = 1'b1;
         1:       begin out_ready = (sink_cyc % 3 == 0); sink_cyc++; end
         default: out_ready = 1'b0;
      endcase
   end

   // Monitor: sample on falling edge, scoreboard pop on each transfer.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && !out_ready) chk("hold_rdy", in_ready, 0);
         if (in_valid && !in_ready) n_stall++;
         if (out_valid && out_ready) begin
            n_res++;
            if (sb.size() == 0) chk("spurious_res", 32'(sb.size()), 1);
            else chk("res", {out_mag, out_edge, out_sof, out_eof}, sb.pop_front());
         end
      end
   end

   // kind: 0 constant 100, 1 vertical step, 2 ramp 10*x. Call at posedge+1.
   task automatic drive_frame(input int kind, input int thr, input int npix,
                              input bit rnd, input bit hold);
      int g;
      for (int k = 0; k < NP; k++)
         img[k] = (kind == 0) ? 100 : (kind == 1) ? ((k % W < 4) ? 0 : 255) : 10 * (k % W);
      for (int k = 0; k < NP; k++) sb.push_back(model(k, thr));
      for (int k = 0; k < npix; k++) begin
         if (rnd) while ($urandom_range(0, 2) == 0) begin
            in_valid = 1'b0; @(posedge clk); #1;
         end
         in_valid  = 1'b1;
         in_pix    = 8'(img[k]);
         // later pixels carry a different threshold that must be ignored
         threshold = (k == 0) ? MW'(thr) : MW'(thr) ^ 11'h3A5;
         g = 0;
         @(negedge clk);
         while (!in_ready && g < 1000) begin @(negedge clk); g++; end
         if (!in_ready) begin
            chk("accept_timeout", g, 0);
            in_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int g = 0;
      while ((sb.size() != 0 || out_valid) && g < 2000) begin @(negedge clk); g++; end
      chk("drain", 32'(sb.size()), 0);
      @(posedge clk); #1;
   endtask

   task automatic run_frame(input string tag, input int kind, input int thr, input bit rnd);
      int n0 = n_res;
      drive_frame(kind, thr, NP, rnd, 1'b0);
      wait_drain();
      chk(tag, n_res - n0, NP);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_ovalid", out_valid, 0);
      chk("rst_omag", out_mag, 0);
      chk("rst_flags", {out_edge, out_sof, out_eof}, 0);
      chk("rst_irdy", in_ready, 1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_frame("n_const", 0, 10, 1'b0);
      run_frame("n_step", 1, 100, 1'b0);
      run_frame("n_ramp80", 2, 80, 1'b0);
      run_frame("n_ramp79", 2, 79, 1'b0);

      sink_mode = 1;
      run_frame("n_step_stall", 1, 100, 1'b1);
      sink_mode = 0;
      repeat (2) @(posedge clk);
      #1;

      // Mid-frame reset with a result held on the output.
      drive_frame(1, 100, 20, 1'b0, 1'b0);
      sink_mode = 2;
      @(negedge clk);
      chk("pre_rst_valid", out_valid, 1);
      #2 rst_n = 1'b0;
      #1 chk("async_rst_valid", out_valid, 0);
      chk("async_rst_mag", out_mag, 0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      sink_mode = 0;
      @(posedge clk); #1;
      run_frame("n_after_rst", 1, 100, 1'b0);

      // Back-to-back frames with in_valid held high.
      begin
         int n0;
         n0 = n_res;
         n_stall = 0;
         drive_frame(1, 100, NP, 1'b0, 1'b1);
         drive_frame(2, 79, NP, 1'b0, 1'b0);
         wait_drain();
         chk("b2b_stall", n_stall, W + 1);
         chk("b2b_nres", n_res - n0, 2 * NP);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/sobel_stream.md
Name: sobel_stream

Overview:
- Streaming 3x3 Sobel edge detector for raster-order greyscale frames of WIDTH x HEIGHT pixels.
- Accepts one pixel per cycle over valid/ready and holds two line buffers plus a 3x3 window, so no whole frame is stored.
- Emits one magnitude/edge result per input pixel, in raster order, with frame markers.
- Sits between the pixel source (image loader/DMA) and the bitmap writer. Successor to the whole-frame Sobel block: parametrised pixel width, handshakes, and correct border handling.

Parameters:
WIDTH, 128, pixels per line (>=3)
HEIGHT, 128, lines per frame (>=3)
PIX_W, 8, bits per input pixel
MAG_W, derived PIX_W+3, magnitude width (localparam, not overridable)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
threshold  in  MAG_W  edge threshold, latched on first pixel of each frame
in_valid  in  1  input pixel valid
in_ready  out  1  block accepts pixel this cycle
in_pix  in  PIX_W  pixel value, raster order
out_valid  out  1  result valid
out_ready  in  1  sink accepts result
out_mag  out  MAG_W  |Gx|+|Gy| of the centre pixel
out_edge  out  1  out_mag > latched threshold
out_sof  out  1  result is pixel (0,0)
out_eof  out  1  result is pixel (WIDTH-1,HEIGHT-1)

Behaviour:
- Reset: asynchronous, active-low, no synchronous clear. Drives out_valid/out_mag/out_edge/out_sof/out_eof=0, state=IDLE, all counters=0, latched threshold=0. Line-buffer contents are not cleared and need not be. Reset mid-frame discards the frame. The first accept after release is pixel (0,0) of a new frame.
- Handshake: a transfer occurs when valid&&ready. in_ready = (state!=FLUSH) && (!out_valid || out_ready). The output register holds its values while out_valid && !out_ready. Simultaneous output drain and input accept gives full 1 pixel/cycle throughput.
- Advance event, on accept or on a FLUSH step:
  - New column = {lb1[x], lb0[x], p}, where x is the input column counter.
  - lb1[x] <= lb0[x]; lb0[x] <= p.
  - The 3x3 window shifts left and takes the new column.
  - In FLUSH, p = 0.
- Kernel is computed combinationally from the post-shift window (p0..p8 row-major, p4 centre):
  - Gx = (p2+2p5+p8)-(p0+2p3+p6)
  - Gy = (p6+2p7+p8)-(p0+2p1+p2)
  - Both are signed, MAG_W+1 bits.
  - mag = |Gx|+|Gy|, unsigned MAG_W bits. Max 8*(2^PIX_W-1), so no overflow and no saturation.
- Centre pixel = accepted index minus D, where D = WIDTH+1.
- Border centres (x==0, x==WIDTH-1, y==0, y==HEIGHT-1) force out_mag=0 and out_edge=0. This also covers window wrap across line ends.
- Latency: a result is registered on the same edge as its triggering advance, so out_valid is high the next cycle.
- States:
  - IDLE: waiting. First accept latches threshold and goes to FILL (count=1).
  - FILL: accepts only, no output. Goes to RUN when accepted count reaches D.
  - RUN: every accept emits one result. Goes to FLUSH on the accept of index WIDTH*HEIGHT-1.
  - FLUSH: in_ready=0. Each cycle with (!out_valid||out_ready) performs a dummy advance and emits. After D emits (the last carries out_eof=1) goes to IDLE.
- The input is pixel 0 of a new frame after IDLE. Back-to-back frames cost D flush cycles of input stall.
- out_sof=1 only on the first result of a frame; out_eof=1 only on the last. Output counters (out_x, out_y) track the centre coordinate and wrap x at WIDTH-1, y at HEIGHT-1.
- in_valid while in FLUSH: held off (in_ready=0), nothing lost.
- Threshold changes mid-frame have no effect until the next frame.

Decomposition:
- Shared package sobel_pkg holds:
  - localparams PIX_W_DEF=8, the MAG_W derivation function, and state encoding (IDLE, FILL, RUN, FLUSH).
  - typedef window_t: 9 x PIX_W array.
- Sub-module sobel_kernel: combinational window_t -> mag. Reusable by later multi-channel variants.
- Line buffers stay inline: two WIDTH x PIX_W arrays, single read/write per cycle at index x, inferable as RAM.

Test Plan (WIDTH=8, HEIGHT=6, PIX_W=8):
- Constant image of all 100s, threshold 10 -> 48 results, all mag=0, edge=0; sof on the first result, eof on the 48th.
- Vertical step (x<4 ->0, x>=4 ->255), threshold 100 -> interior rows y=1..4 give mag=1020, edge=1 at x=3 and x=4; all other results 0.
- Ramp pix=10*x: threshold 80 -> interior mag=80, edge=0; next frame with threshold 79 -> edge=1. Verifies strict compare and per-frame latch.
- Step image with out_ready toggling 1-of-3 cycles and in_valid random -> result stream identical to the no-stall run; no drop or duplicate; in_ready low whenever out_valid && !out_ready.
- rst_n pulsed low after 20 accepts -> out_valid=0 immediately, asynchronously. A fresh full frame then yields a correct 48-result stream with sof on the first.
- Two back-to-back frames with in_valid held high -> in_ready low for exactly 9 cycles between frames; 96 results total; eof on results 48 and 96.
